// File: rtl/db_switch_ctrl.sv
// Double-buffer bank-switch controller: sequences producer writes and consumer reads per tile and pulses a bank swap.
// Optional sticky protocol-error flag on output err is enabled by defining DB_SWITCH_ERR_EN.
module db_switch_ctrl #(
  parameter int unsigned DEPTH_W = 16,
  parameter int unsigned TILE_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               flush,
  input  logic [DEPTH_W-1:0] depth,
  input  logic               wen_req,
  input  logic               ren_req,
  output logic               wen_out,
  output logic               ren_out,
  output logic               wr_ready,
  output logic               rd_ready,
  output logic               switch_db,
  output logic               bank_sel,
  output logic [TILE_W-1:0]  tile_cnt
`ifdef DB_SWITCH_ERR_EN
  ,
  output logic               err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_SWAP = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DEPTH_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [DEPTH_W-1:0] rd_cnt_q, rd_cnt_d;
  logic               bank_q, bank_d;
  logic [TILE_W-1:0]  tile_q, tile_d;
  logic [DEPTH_W-1:0] wr_inc, rd_inc;

  // Handshake and strobes are decoded from registered state with zero latency.
  assign wr_ready  = ((state_q == S_FILL) || (state_q == S_RUN)) && (wr_cnt_q < depth_q);
  assign rd_ready  = (state_q == S_RUN) && (rd_cnt_q < depth_q);
  assign wen_out   = wen_req & wr_ready & clk_en;
  assign ren_out   = ren_req & rd_ready & clk_en;
  assign switch_db = (state_q == S_SWAP) & clk_en;
  assign bank_sel  = bank_q;
  assign tile_cnt  = tile_q;

  assign wr_inc = wr_cnt_q + DEPTH_W'(wen_out);
  assign rd_inc = rd_cnt_q + DEPTH_W'(ren_out);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      depth_q  <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      bank_q   <= 1'b0;
      tile_q   <= '0;
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      bank_q   <= bank_d;
      tile_q   <= tile_d;
    end
  end

  // Next-state logic; clk_en low freezes everything, flush overrides every transition.
  always_comb begin
    state_d  = state_q;
    depth_d  = depth_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    bank_d   = bank_q;
    tile_d   = tile_q;
    if (clk_en) begin
      if (flush) begin
        state_d  = S_IDLE;
        wr_cnt_d = '0;
        rd_cnt_d = '0;
        bank_d   = 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (depth != '0) begin
              depth_d = depth;
              state_d = S_FILL;
            end
          end
          S_FILL: begin
            wr_cnt_d = wr_inc;
            if (wr_inc == depth_q) state_d = S_SWAP;
          end
          S_RUN: begin
            wr_cnt_d = wr_inc;
            rd_cnt_d = rd_inc;
            if ((wr_inc == depth_q) && (rd_inc == depth_q)) state_d = S_SWAP;
          end
          S_SWAP: begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            bank_d   = ~bank_q;
            tile_d   = tile_q + TILE_W'(1);
            state_d  = S_RUN;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

`ifdef DB_SWITCH_ERR_EN
  logic err_q, err_d;

  // Sticky flag for any request that arrives while its side is not ready.
  always_comb begin
    err_d = err_q;
    if (clk_en) begin
      if (flush) begin
        err_d = 1'b0;
      end else if ((state_q != S_IDLE) &&
                   ((wen_req && !wr_ready) || (ren_req && !rd_ready))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_db_switch_ctrl.sv
// Scoreboard bench for db_switch_ctrl: expectations are queued with each stimulus phase and popped after it runs.
module tb_db_switch_ctrl;

  localparam int unsigned DEPTH_W = 16;
  localparam int unsigned TILE_W  = 16;

  logic               clk;
  logic               reset;
  logic               clk_en;
  logic               flush;
  logic [DEPTH_W-1:0] depth;
  logic               wen_req;
  logic               ren_req;
  logic               wen_out;
  logic               ren_out;
  logic               wr_ready;
  logic               rd_ready;
  logic               switch_db;
  logic               bank_sel;
  logic [TILE_W-1:0]  tile_cnt;
`ifdef DB_SWITCH_ERR_EN
  logic               err;
`endif

  db_switch_ctrl #(.DEPTH_W(DEPTH_W), .TILE_W(TILE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .flush     (flush),
    .depth     (depth),
    .wen_req   (wen_req),
    .ren_req   (ren_req),
    .wen_out   (wen_out),
    .ren_out   (ren_out),
    .wr_ready  (wr_ready),
    .rd_ready  (rd_ready),
    .switch_db (switch_db),
    .bank_sel  (bank_sel),
    .tile_cnt  (tile_cnt)
`ifdef DB_SWITCH_ERR_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned val;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          c_wen, c_ren, c_sw, c_first_sw, c_last_wen, c_last_ren, c_wblk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int unsigned val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(e.tag, obs, 32'(e.val));
    end
  endtask

  // Runs n cycles with inputs held; outputs sampled on the falling edge. Cycle indices start at 1.
  task automatic run_cycles(input int n);
    c_wen = 0; c_ren = 0; c_sw = 0; c_first_sw = 0;
    c_last_wen = 0; c_last_ren = 0; c_wblk = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (wen_out) begin c_wen++; c_last_wen = i; end
      if (ren_out) begin c_ren++; c_last_ren = i; end
      if (switch_db) begin
        c_sw++;
        if (c_first_sw == 0) c_first_sw = i;
      end
      if (!wr_ready && rd_ready) c_wblk++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    clk_en  = 1'b1;
    flush   = 1'b0;
    depth   = '0;
    wen_req = 1'b0;
    ren_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Fill a fresh tile of depth d with writes only; leaves the DUT in RUN with tile_cnt=1.
  task automatic fill_from_reset(input int d, input string tag);
    do_reset();
    depth   = DEPTH_W'(d);
    wen_req = 1'b1;
    sb_push({tag, "_fill_wen"}, d);
    sb_push({tag, "_fill_sw"},  d + 2);
    run_cycles(d + 2);
    sb_pop(32'(c_wen));
    sb_pop(32'(c_first_sw));
  endtask

  initial begin
    // Outputs during reset, with requests asserted
    reset = 1'b0; clk_en = 1'b1; flush = 1'b0; depth = 16'd5;
    wen_req = 1'b1; ren_req = 1'b1;
    #2;
    sb_push("rst_wen", 0); sb_push("rst_ren", 0); sb_push("rst_wrdy", 0);
    sb_push("rst_rrdy", 0); sb_push("rst_sw", 0); sb_push("rst_bank", 0);
    sb_push("rst_tile", 0);
    sb_pop(32'(wen_out)); sb_pop(32'(ren_out)); sb_pop(32'(wr_ready));
    sb_pop(32'(rd_ready)); sb_pop(32'(switch_db)); sb_pop(32'(bank_sel));
    sb_pop(32'(tile_cnt));

    // IDLE holds while depth is zero
    do_reset();
    wen_req = 1'b1;
    sb_push("idle_wen", 0);
    run_cycles(3);
    sb_pop(32'(c_wen));
    sb_push("idle_wrdy", 0);
    sb_pop(32'(wr_ready));

    // depth=3 fill from reset: swap on cycle 5
    do_reset();
    depth = 16'd3; wen_req = 1'b1;
    sb_push("a_wen", 3); sb_push("a_sw_cnt", 1); sb_push("a_sw_cyc", 5);
    run_cycles(5);
    sb_pop(32'(c_wen)); sb_pop(32'(c_sw)); sb_pop(32'(c_first_sw));
    sb_push("a_bank", 1); sb_push("a_tile", 1); sb_push("a_rrdy", 1);
    sb_pop(32'(bank_sel)); sb_pop(32'(tile_cnt)); sb_pop(32'(rd_ready));

    // depth=9 steady RUN with both sides every cycle
    fill_from_reset(9, "b");
    ren_req = 1'b1;
    sb_push("b_wen", 9); sb_push("b_ren", 9); sb_push("b_last_wen", 9);
    sb_push("b_last_ren", 9); sb_push("b_sw_cyc", 10); sb_push("b_sw_cnt", 1);
    run_cycles(10);
    sb_pop(32'(c_wen)); sb_pop(32'(c_ren)); sb_pop(32'(c_last_wen));
    sb_pop(32'(c_last_ren)); sb_pop(32'(c_first_sw)); sb_pop(32'(c_sw));
    sb_push("b_tile", 2); sb_push("b_bank", 0);
    sb_pop(32'(tile_cnt)); sb_pop(32'(bank_sel));

    // depth=4 writes finish three cycles ahead of reads
    fill_from_reset(4, "c");
    ren_req = 1'b0;
    sb_push("c_p1_wen", 3); sb_push("c_p1_ren", 0);
    run_cycles(3);
    sb_pop(32'(c_wen)); sb_pop(32'(c_ren));
    ren_req = 1'b1;
    sb_push("c_p2_wen", 1); sb_push("c_p2_ren", 4); sb_push("c_wblk", 3);
    sb_push("c_sw_cnt", 1); sb_push("c_sw_cyc", 5);
    run_cycles(5);
    sb_pop(32'(c_wen)); sb_pop(32'(c_ren)); sb_pop(32'(c_wblk));
    sb_pop(32'(c_sw)); sb_pop(32'(c_first_sw));

    // depth=4 with clk_en low for two cycles mid-RUN
    fill_from_reset(4, "d");
    ren_req = 1'b1;
    sb_push("d_p1_wen", 2); sb_push("d_p1_ren", 2);
    run_cycles(2);
    sb_pop(32'(c_wen)); sb_pop(32'(c_ren));
    clk_en = 1'b0;
    sb_push("d_off_wen", 0); sb_push("d_off_ren", 0); sb_push("d_off_sw", 0);
    run_cycles(2);
    sb_pop(32'(c_wen)); sb_pop(32'(c_ren)); sb_pop(32'(c_sw));
    clk_en = 1'b1;
    sb_push("d_p2_wen", 2); sb_push("d_p2_ren", 2); sb_push("d_sw_cyc", 3);
    run_cycles(3);
    sb_pop(32'(c_wen)); sb_pop(32'(c_ren)); sb_pop(32'(c_first_sw));
    sb_push("d_tile", 2);
    sb_pop(32'(tile_cnt));

    // Flush at wr_cnt=2 in RUN
    fill_from_reset(4, "e");
    sb_push("e_wen", 2);
    run_cycles(2);
    sb_pop(32'(c_wen));
    wen_req = 1'b0; flush = 1'b1;
    run_cycles(1);
    flush = 1'b0;
    sb_push("e_wrdy", 0); sb_push("e_rrdy", 0); sb_push("e_bank", 0); sb_push("e_tile", 1);
    sb_pop(32'(wr_ready)); sb_pop(32'(rd_ready)); sb_pop(32'(bank_sel)); sb_pop(32'(tile_cnt));

    // Reset mid-FILL forces outputs low immediately
    depth = 16'd2; wen_req = 1'b1;
    run_cycles(2);
    reset = 1'b0;
    #1;
    sb_push("f_wen", 0); sb_push("f_wrdy", 0); sb_push("f_tile", 0); sb_push("f_sw", 0);
    sb_pop(32'(wen_out)); sb_pop(32'(wr_ready)); sb_pop(32'(tile_cnt)); sb_pop(32'(switch_db));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fresh tile after reset; depth change outside IDLE is ignored
    run_cycles(1);
    depth = 16'd7;
    sb_push("g_wen", 2); sb_push("g_sw_cyc", 3);
    run_cycles(3);
    sb_pop(32'(c_wen)); sb_pop(32'(c_first_sw));
    sb_push("g_tile", 1);
    sb_pop(32'(tile_cnt));

`ifdef DB_SWITCH_ERR_EN
    // Read request during FILL flags err until flush
    do_reset();
    depth = 16'd4; ren_req = 1'b1;
    sb_push("h_ren", 0);
    run_cycles(3);
    sb_pop(32'(c_ren));
    ren_req = 1'b0;
    sb_push("h_err", 1);
    sb_pop(32'(err));
    flush = 1'b1;
    run_cycles(1);
    flush = 1'b0;
    sb_push("h_err_clr", 0);
    sb_pop(32'(err));
`endif

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/db_switch_ctrl.md
DB_SWITCH_CTRL -- requirements
Module: db_switch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_W, default 16, the width of depth and of the word counters.
REQ-002 SHALL have parameter TILE_W, default 16, the width of the completed-tile counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clk_en  input  1  global enable; when low, all state is frozen.
REQ-006 SHALL have port flush  input  1  synchronous return to IDLE.
REQ-007 SHALL have port depth  input  DEPTH_W  words per tile; sampled only in IDLE.
REQ-008 SHALL have port wen_req  input  1  producer write request.
REQ-009 SHALL have port ren_req  input  1  consumer read request.
REQ-010 SHALL have port wen_out  output  1  write strobe to memory core.
REQ-011 SHALL have port ren_out  output  1  read strobe to memory core.
REQ-012 SHALL have port wr_ready / rd_ready  output  1 each  producer/consumer may issue this cycle.
REQ-013 SHALL have port switch_db  output  1  bank-swap pulse to memory core.
REQ-014 SHALL have port bank_sel  output  1  bank currently being written.
REQ-015 SHALL have port tile_cnt  output  TILE_W  count of completed swaps, wrapping.

Function
REQ-016 SHALL implement states IDLE, FILL, RUN, SWAP, held in a registered state variable.
REQ-017 IDLE SHALL hold while depth==0; depth!=0 SHALL latch depth_q and go to FILL next edge.
REQ-018 wr_ready SHALL equal (state in FILL or RUN) and wr_cnt<depth_q; rd_ready SHALL equal state==RUN and rd_cnt<depth_q.
REQ-019 wen_out SHALL equal wen_req & wr_ready & clk_en, and ren_out SHALL equal ren_req & rd_ready & clk_en, both combinational with zero latency.
REQ-020 wr_cnt/rd_cnt SHALL increment by 1 on each accepted write/read and never exceed depth_q.
REQ-021 FILL SHALL go to SWAP on the edge where the accepted write makes wr_cnt==depth_q; reads are blocked in FILL.
REQ-022 RUN SHALL go to SWAP once wr_cnt==depth_q and rd_cnt==depth_q, including the case where the final write and the final read are accepted in the same cycle.
REQ-023 If one side finishes first, it SHALL hold ready low, with no acceptance, until the other side finishes.
REQ-024 SWAP SHALL last one cycle with switch_db=1 and both readies low.
REQ-025 On SWAP exit, SWAP SHALL clear both counters, toggle bank_sel, increment tile_cnt (modulo 2^TILE_W), and enter RUN.
REQ-026 switch_db SHALL be 1 only in SWAP with clk_en high.
REQ-027 flush SHALL take priority over all transitions: next state IDLE, counters 0, bank_sel 0; tile_cnt is unchanged.
REQ-028 With clk_en low, state and counters SHALL hold and all strobes SHALL be 0.
REQ-029 A change to depth outside IDLE SHALL have no effect until the next IDLE.

Reset
REQ-030 reset low SHALL asynchronously force state IDLE, wr_cnt=0, rd_cnt=0, depth_q=0, bank_sel=0, tile_cnt=0.
REQ-031 During reset, all outputs SHALL be 0.
REQ-032 Reset asserted mid-tile SHALL discard partial progress, with no switch_db pulse.
REQ-033 Reset deassertion SHALL be synchronised by the caller; the first edge after release evaluates IDLE.

Configuration
REQ-034 Macro DB_SWITCH_ERR_EN SHALL, when defined, add output err (1 bit), sticky, set when wen_req&!wr_ready or ren_req&!rd_ready while clk_en=1 and state!=IDLE; err is cleared only by reset or flush.
REQ-035 Without DB_SWITCH_ERR_EN, err SHALL be absent and blocked requests SHALL be silently dropped.

Verification
REQ-036 depth=3, wen_req=1 continuously from IDLE -> FILL accepts 3 writes, switch_db pulses on cycle 5 after reset release, bank_sel=1, tile_cnt=1.
REQ-037 depth=9, RUN with wen_req=ren_req=1 every cycle -> both final acceptances are in the same cycle, SWAP on the next cycle, exactly 9 wen_out and 9 ren_out per tile.
REQ-038 depth=4, writes finish 3 cycles before reads -> wr_ready stays low for 3 cycles, no extra wen_out, then one switch_db.
REQ-039 depth=4, clk_en low for 2 cycles mid-RUN -> counters frozen, no strobes, the tile completes with exact counts afterwards.
REQ-040 flush asserted at wr_cnt=2 in RUN -> IDLE next cycle, bank_sel=0, tile_cnt unchanged; reset low mid-FILL -> all outputs 0 immediately.
REQ-041 With DB_SWITCH_ERR_EN defined, ren_req=1 during FILL -> err=1 and ren_out=0; err stays 1 until flush.
